// File: rtl/popcount14_vec_gen.sv
// popcount14_vec_gen: enumerates every N-bit vector with exactly k ones in increasing order over a valid/ready stream
module popcount14_vec_gen #(
    parameter int N  = 14,
    parameter int CW = 4,
    parameter int IW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [CW-1:0] k,
    output logic          busy,
    output logic          vec_valid,
    input  logic          vec_ready,
    output logic [N-1:0]  vec_data,
    output logic [CW-1:0] vec_count,
    output logic [IW-1:0] vec_idx,
    output logic          vec_last,
    output logic          done,
    output logic          err
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [N:0] ONE = (N+1)'(1);
    state_t        state, state_n;
    logic          go, hs;
    logic [N:0]    v, c, r;
    logic [CW-1:0] tz;
    logic [N-1:0]  nxt, last_pat;
    assign go        = state == IDLE && start && k <= CW'(N);
    assign vec_valid = state == RUN;
    assign busy      = state != IDLE;
    assign done      = state == DONE;
    assign hs        = vec_valid & vec_ready;
    // Gosper's successor in N+1 bits; the divide by c becomes a shift by ctz(c)
    assign v   = {1'b0, vec_data};
    assign c   = v & (~v + ONE);
    assign r   = v + c;
    assign nxt = N'(r | (((r ^ v) >> 2) >> tz));
    always_comb begin
        tz = '0;
        for (int i = N - 1; i >= 0; i--)
            if (c[i]) tz = CW'(i);
    end
    // final vector is the k ones packed against the MSB
    assign last_pat = ~N'((ONE << (CW'(N) - vec_count)) - ONE);
    assign vec_last = vec_valid && vec_data == last_pat;
    always_comb begin
        state_n = state;
        if (go) state_n = RUN;
        else if (hs && vec_last) state_n = DONE;
        else if (state == DONE) state_n = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            err       <= 1'b0;
            vec_data  <= '0;
            vec_count <= '0;
            vec_idx   <= '0;
        end else begin
            state <= state_n;
            err   <= state == IDLE && start && k > CW'(N);
            if (go) begin
                vec_data  <= N'((ONE << k) - ONE);
                vec_count <= k;
                vec_idx   <= '0;
            end else if (hs && !vec_last) begin
                vec_data <= nxt;
                vec_idx  <= vec_idx + IW'(1);
            end
        end
    end
endmodule

// File: tb/tb_popcount14_vec_gen.sv
// tb_popcount14_vec_gen: directed runs checked every cycle against a list-based enumeration model
module tb_popcount14_vec_gen;
    logic        clk = 0, rst_n = 0, start = 0, vec_ready = 0;
    logic [3:0]  k = 0;
    logic        busy, vec_valid, vec_last, done, err;
    logic [13:0] vec_data;
    logic [3:0]  vec_count;
    logic [11:0] vec_idx;
    int checks = 0, errors = 0, cyc = 0;
    int done_cnt = 0, err_cnt = 0, s_cyc = 0, done_cyc = 0, last_cnt = 0;
    logic [13:0] exp_q[$], got[$];
    bit  m_run = 0, m_done = 0, m_err = 0;
    int  mi = 0, mk = 0;

    popcount14_vec_gen dut (.clk(clk), .rst_n(rst_n), .start(start), .k(k), .busy(busy),
        .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_data(vec_data), .vec_count(vec_count),
        .vec_idx(vec_idx), .vec_last(vec_last), .done(done), .err(err));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0h want %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // model: expected stream is the sorted list of all 14-bit values with popcount k
    always @(negedge clk) begin
        bit nr, nd, ne;
        if (!rst_n) begin
            chk("rst_valid", vec_valid, 0); chk("rst_busy", busy, 0); chk("rst_last", vec_last, 0);
            chk("rst_done", done, 0); chk("rst_err", err, 0); chk("rst_data", vec_data, 0);
            chk("rst_count", vec_count, 0); chk("rst_idx", vec_idx, 0);
            m_run = 0; m_done = 0; m_err = 0;
        end else begin
            chk("valid", vec_valid, m_run);
            chk("busy", busy, m_run | m_done);
            chk("done", done, m_done);
            chk("err", err, m_err);
            if (m_run) begin
                chk("data", vec_data, exp_q[mi]);
                chk("idx", vec_idx, mi);
                chk("count", vec_count, mk);
                chk("last", vec_last, mi == exp_q.size() - 1);
            end
            if (vec_valid && vec_ready) begin
                got.push_back(vec_data);
                last_cnt = vec_count;
            end
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (err) err_cnt++;
            nr = m_run; nd = 0; ne = 0;
            if (m_run && vec_ready) begin
                if (mi == exp_q.size() - 1) begin nr = 0; nd = 1; end
                else mi++;
            end
            if (!m_run && !m_done && start) begin
                if (k <= 14) begin
                    exp_q.delete();
                    for (int x = 0; x < 16384; x++)
                        if ($countones(14'(x)) == int'(k)) exp_q.push_back(14'(x));
                    mk = k; mi = 0; nr = 1; s_cyc = cyc;
                end else ne = 1;
            end
            m_run = nr; m_done = nd; m_err = ne;
        end
    end

    task automatic run_k(input int kk, input bit rnd, input bit poke);
        int d0;
        d0 = done_cnt;
        got.delete();
        @(posedge clk); #1;
        start = 1; k = 4'(kk); vec_ready = 1;
        @(posedge clk); #1;
        start = 0;
        for (int i = 0; i < 20000 && done_cnt == d0; i++) begin
            vec_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start = poke && i == 5;
            if (poke) k = 4'd9;
            @(posedge clk); #1;
        end
        start = 0;
        chk("done_seen", done_cnt - d0, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        int bad, e0, d0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        run_k(0, 0, 0);
        chk("k0_n", got.size(), 1);
        chk("k0_v", got[0], 14'h0000);
        chk("k0_lat", done_cyc - s_cyc, 2);
        run_k(14, 0, 0);
        chk("k14_n", got.size(), 1);
        chk("k14_v", got[0], 14'h3FFF);
        chk("k14_cnt", last_cnt, 14);
        run_k(2, 0, 1);
        chk("k2_v0", got[0], 14'h0003);
        chk("k2_v1", got[1], 14'h0005);
        chk("k2_v2", got[2], 14'h0006);
        chk("k2_v3", got[3], 14'h0009);
        chk("k2_n", got.size(), 91);
        chk("k2_vlast", got[90], 14'h3000);
        chk("k2_rate", done_cyc - s_cyc, 92);
        run_k(7, 1, 0);
        chk("k7_n", got.size(), 3432);
        bad = 0;
        for (int i = 0; i < got.size(); i++) begin
            if ($countones(got[i]) != 7) bad++;
            if (i > 0 && got[i] <= got[i-1]) bad++;
        end
        chk("k7_order_pop", bad, 0);
        e0 = err_cnt;
        @(posedge clk); #1;
        start = 1; k = 4'd15;
        @(posedge clk); #1;
        start = 0;
        repeat (3) @(posedge clk);
        #1 chk("k15_err", err_cnt - e0, 1);
        chk("k15_busy", busy, 0);
        run_k(1, 0, 0);
        chk("k1_n", got.size(), 14);
        chk("k1_first", got[0], 14'h0001);
        chk("k1_lastv", got[13], 14'h2000);
        got.delete();
        @(posedge clk); #1;
        start = 1; k = 4'd5; vec_ready = 1;
        @(posedge clk); #1;
        start = 0;
        for (int i = 0; i < 100 && got.size() < 10; i++) begin @(posedge clk); #1; end
        chk("k5_ten", got.size() >= 10, 1);
        d0 = done_cnt;
        rst_n = 0;
        #1;
        chk("ar_valid", vec_valid, 0); chk("ar_busy", busy, 0);
        chk("ar_data", vec_data, 0); chk("ar_idx", vec_idx, 0); chk("ar_count", vec_count, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        repeat (2) @(posedge clk);
        #1 chk("ar_nodone", done_cnt - d0, 0);
        run_k(5, 0, 0);
        chk("k5_first", got[0], 14'h001F);
        chk("k5_n", got.size(), 2002);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/popcount14_vec_gen.md
# popcount14_vec_gen

Sequential stimulus generator for the 14-input popcount units. Given a target count `k`, it emits every 14-bit vector with exactly `k` ones, one per handshake, in strictly increasing numeric order, tagged with the exact count. It drives the input side of an approximate popcount core so that per-count error statistics (MAE, worst case) can be accumulated exhaustively in hardware.

## Interface
- `N`, 14, vector width (number of popcount inputs)
- `CW`, 4, count width, equal to $clog2(N+1)
- `IW`, 12, index width; must hold C(N, N/2)-1 = 3431

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  request enumeration; sampled only in IDLE
- `k`  in  CW  target popcount; sampled with `start`
- `busy`  out  1  high in RUN and DONE
- `vec_valid`  out  1  `vec_data` holds a valid vector
- `vec_ready`  in  1  consumer accepts the vector
- `vec_data`  out  N  current vector, ordinal `vec_idx`
- `vec_count`  out  CW  exact popcount of `vec_data` (latched `k`)
- `vec_idx`  out  IW  ordinal of current vector, starting at 0
- `vec_last`  out  1  current vector is the final one for this `k`
- `done`  out  1  one-cycle pulse after the final handshake
- `err`  out  1  one-cycle pulse when `start` carries `k > N`

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `start`=1 and `k` ≤ N: latch `k`, load `vec_data` = (1<<k)-1, load `vec_idx` = 0, go to RUN.
  - `start`=1 and `k` > N: pulse `err`, stay in IDLE.
- RUN:
  - `vec_valid`=1.
  - Handshake is `vec_valid & vec_ready`.
  - On a handshake with `vec_last`=0: `vec_data` ← next(`vec_data`) and `vec_idx` ← `vec_idx`+1.
  - On a handshake with `vec_last`=1: go to DONE.
  - With no handshake, all `vec_*` outputs hold their values.
- DONE: `done`=1 and `vec_valid`=0 for one cycle, then go to IDLE.
- `start` is ignored in RUN and DONE.
- `vec_last` = (`vec_data` == ((1<<k)-1) << (N-k)). This value is 0 for `k`=0 and 0x3FFF for `k`=N, so each of those cases produces exactly one vector.
- next(v) uses Gosper's successor, computed in N+1 bits:
  - c = v & -v
  - r = v + c
  - next = r | (((r ^ v) >> 2) >> ctz(c))
  - Division by c is realised as a shift by a trailing-zero count from a priority encoder; no divider.
  - next is never evaluated when `vec_last`=1, so bit N of r stays 0 on every used path.
- Emitted vector count for `k` = C(N, k). The final `vec_idx` = C(N, k)-1.
- `vec_count` is constant for a whole run and equals the popcount of every emitted vector.

## Timing
- Reset (asynchronous, immediate): state IDLE; `busy`, `vec_valid`, `vec_last`, `done`, `err` = 0; `vec_data`, `vec_count`, `vec_idx` = 0.
- Reset asserted mid-RUN aborts the run with no `done`. The first `start` after release behaves as if from power-up.
- `start` sampled at edge t: `vec_valid`=1 from cycle t+1 with the first vector.
- Throughput is one vector per cycle while `vec_ready` is held high. next() is single-cycle combinational off registered `vec_data`.
- Final handshake at edge t: `done`=1 during cycle t+1; `busy` falls and IDLE is reached at edge t+2. The earliest accepted new `start` is sampled at t+2.
- `err` is asserted in the cycle after `start` is sampled.
- `vec_valid` never drops without a handshake (AXI-style). `vec_data`, `vec_idx`, `vec_last` and `vec_count` are stable while `vec_valid & !vec_ready`.
- `vec_ready` may be high before `vec_valid`; no combinational path from `vec_ready` to `vec_valid`.

## Test plan
- `k`=0, `vec_ready`=1 → exactly one vector 0x0000, `vec_idx`=0, `vec_last`=1; `done` pulses 2 cycles after `start`.
- `k`=14 → exactly one vector 0x3FFF with `vec_last`=1 and `vec_count`=14, then `done`.
- `k`=2, `vec_ready`=1 →
  - first vectors 0x0003, 0x0005, 0x0006, 0x0009;
  - 91 vectors in total, the last 0x3000 with `vec_idx`=90;
  - one vector per cycle.
- `k`=7, random `vec_ready` (~50%) → 3432 vectors, strictly increasing, each popcount 7 and distinct, final `vec_idx`=3431; scoreboard checks stability during stalls.
- `k`=15 → `err` pulses one cycle, `vec_valid` stays 0, `busy` stays 0. A following `start` with `k`=1 yields 0x0001 … 0x2000 (14 vectors).
- Reset pulse after 10 handshakes of a `k`=5 run → all outputs 0 immediately, no `done`. A new `start` with `k`=5 restarts at 0x001F with `vec_idx`=0.
